// File: rtl/psum_accumulate_quant.sv
// psum_accumulate_quant: per-channel accumulation of ROUND_NUM partial-sum beats,
// then bias, ReLU, requantizing shift and saturation to an unsigned activation. Rev 1.0
`default_nettype none

module psum_accumulate_quant #(
  parameter int CHANNEL_NUM = 128,
  parameter int ROUND_NUM   = 9,
  parameter int ACC_WIDTH   = 12,
  parameter int SHIFT       = 2,
  parameter int OUT_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 clear,
  input  logic                                 data_in_valid,
  input  logic [CHANNEL_NUM-1:0][7:0]          data_in,
  input  logic [CHANNEL_NUM-1:0][7:0]          bias_in,
  output logic                                 data_out_valid,
  output logic [CHANNEL_NUM-1:0][OUT_WIDTH-1:0] data_out,
  output logic                                 busy
);

  localparam int                       CNT_W    = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(ROUND_NUM - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH + 1)'((1 << OUT_WIDTH) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             accept;
  logic             beat_last;

  // A beat arriving together with clear is discarded.
  assign accept    = data_in_valid & ~clear;
  assign beat_last = accept && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (data_in_valid) begin
      cnt_d  = beat_last ? '0 : cnt_q + 1'b1;
      done_d = beat_last;
    end
    valid_d = done_q & ~clear;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy           = (cnt_q != '0);
  assign data_out_valid = valid_q;

  generate
    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
      logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
      logic signed [ACC_WIDTH-1:0] din_ext;
      logic signed [ACC_WIDTH:0]   sum_w;
      logic signed [ACC_WIDTH:0]   shr_w;
      logic [OUT_WIDTH-1:0]        q_w;
      logic [OUT_WIDTH-1:0]        out_q, out_d;

      assign din_ext = {{(ACC_WIDTH-8){data_in[g][7]}}, data_in[g]};
      assign sum_w   = {acc_q[ACC_WIDTH-1], acc_q} + {{(ACC_WIDTH-7){bias_in[g][7]}}, bias_in[g]};
      assign shr_w   = sum_w >>> SHIFT;

      always_comb begin
        acc_d = acc_q;
        if (accept) begin
          acc_d = (cnt_q == '0) ? din_ext : acc_q + din_ext;
        end
      end

      // Non-positive sums clamp to zero; large ones saturate at the output range.
      always_comb begin
        q_w = '0;
        if (!sum_w[ACC_WIDTH] && (sum_w != '0)) begin
          if (shr_w > OUT_MAX) begin
            q_w = OUT_MAX[OUT_WIDTH-1:0];
          end else begin
            q_w = shr_w[OUT_WIDTH-1:0];
          end
        end
      end

      // The output register samples acc on the same edge a new pixel overwrites it.
      assign out_d = valid_d ? q_w : out_q;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          acc_q <= '0;
          out_q <= '0;
        end else begin
          acc_q <= acc_d;
          out_q <= out_d;
        end
      end

      assign data_out[g] = out_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_psum_accumulate_quant.sv
// tb_psum_accumulate_quant: randomized and directed checks of psum_accumulate_quant
// against an arithmetic reference model. Rev 1.0
`default_nettype none

module tb_psum_accumulate_quant;

  localparam int CH    = 128;
  localparam int ROUND = 9;
  localparam int SH    = 2;
  localparam int OW    = 4;

  logic                    clk;
  logic                    rstn;
  logic                    clear;
  logic                    data_in_valid;
  logic [CH-1:0][7:0]      data_in;
  logic [CH-1:0][7:0]      bias_in;
  logic                    data_out_valid;
  logic [CH-1:0][OW-1:0]   data_out;
  logic                    busy;

  int nvec;
  int nerr;

  logic [CH-1:0][7:0]    beats [ROUND];
  logic [CH-1:0][OW-1:0] exp_out;

  psum_accumulate_quant #(
    .CHANNEL_NUM(CH),
    .ROUND_NUM  (ROUND),
    .ACC_WIDTH  (12),
    .SHIFT      (SH),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .clear         (clear),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .bias_in       (bias_in),
    .data_out_valid(data_out_valid),
    .data_out      (data_out),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of beats plus bias, ReLU, floor divide by 2^SHIFT, saturate.
  function automatic logic [CH-1:0][OW-1:0] model();
    logic [CH-1:0][OW-1:0] r;
    int s;
    int q;
    for (int c = 0; c < CH; c++) begin
      s = 0;
      for (int b = 0; b < ROUND; b++) s += int'($signed(beats[b][c]));
      s += int'($signed(bias_in[c]));
      if (s <= 0) q = 0;
      else q = s / (1 << SH);
      if (q > (1 << OW) - 1) q = (1 << OW) - 1;
      r[c] = OW'(q);
    end
    return r;
  endfunction

  task automatic fill_const(input logic [7:0] d);
    for (int b = 0; b < ROUND; b++) for (int c = 0; c < CH; c++) beats[b][c] = d;
  endtask

  task automatic run_pixel(input string name, input int idle_max);
    int n;
    exp_out = model();
    for (int b = 0; b < ROUND; b++) begin
      data_in       = beats[b];
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
      nvec++;
      if (busy !== (b != ROUND - 1)) begin
        nerr++;
        $display("FAIL %s busy beat %0d: got %b want %b", name, b, busy, (b != ROUND - 1));
      end
      nvec++;
      if (data_out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL %s early valid beat %0d: got %b want 0", name, b, data_out_valid);
      end
      if (b < ROUND - 1) begin
        n = (idle_max > 0) ? int'($urandom_range(idle_max)) : 0;
        for (int i = 0; i < n; i++) begin
          step();
          nvec++;
          if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL %s busy idle: got %b want 1", name, busy);
          end
        end
      end
    end
    step();
    nvec++;
    if (data_out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL %s valid pulse: got %b want 1", name, data_out_valid);
    end
    nvec++;
    if (data_out !== exp_out) begin
      nerr++;
      $display("FAIL %s data_out: got %h want %h", name, data_out, exp_out);
    end
    step();
    nvec++;
    if (data_out_valid !== 1'b0 || data_out !== exp_out) begin
      nerr++;
      $display("FAIL %s hold: valid %b data %h want valid 0 data %h", name, data_out_valid, data_out, exp_out);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    nvec++;
    if (data_out_valid !== 1'b0 || data_out !== '0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset: valid %b busy %b data %h want all 0", data_out_valid, busy, data_out);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bias_in = '0;
    fill_const(8'd5);
    run_pixel("basic", 0);
    nvec++;
    if (data_out !== {CH{4'd11}}) begin
      nerr++;
      $display("FAIL basic const: got %h want all 11", data_out);
    end
  endtask

  task automatic test_saturate_relu();
    bias_in = '0;
    fill_const(8'd20);
    run_pixel("saturate", 0);
    nvec++;
    if (data_out !== {CH{4'd15}}) begin
      nerr++;
      $display("FAIL saturate const: got %h want all 15", data_out);
    end
    bias_in = {CH{8'd10}};
    fill_const(8'hFD);
    run_pixel("relu", 0);
    nvec++;
    if (data_out !== '0) begin
      nerr++;
      $display("FAIL relu const: got %h want 0", data_out);
    end
  endtask

  task automatic test_idle();
    bias_in = {CH{8'd3}};
    fill_const(8'd1);
    run_pixel("idle", 3);
    nvec++;
    if (data_out !== {CH{4'd3}}) begin
      nerr++;
      $display("FAIL idle const: got %h want all 3", data_out);
    end
  endtask

  task automatic test_clear();
    bias_in = '0;
    data_in = {CH{8'd7}};
    for (int b = 0; b < 4; b++) begin
      data_in_valid = 1'b1;
      step();
    end
    clear = 1'b1;
    step();
    clear         = 1'b0;
    data_in_valid = 1'b0;
    nvec++;
    if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL clear state: busy %b valid %b want 0 0", busy, data_out_valid);
    end
    step();
    nvec++;
    if (data_out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL clear stray valid: got %b want 0", data_out_valid);
    end
    fill_const(8'd1);
    run_pixel("after_clear", 0);
    nvec++;
    if (data_out !== {CH{4'd2}}) begin
      nerr++;
      $display("FAIL after_clear const: got %h want all 2", data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic                  want_v;
    logic [CH-1:0][OW-1:0] want_d;
    bias_in = '0;
    for (int k = 0; k < 2 * ROUND + 3; k++) begin
      data_in_valid = (k < 2 * ROUND);
      data_in       = (k < ROUND) ? {CH{8'd4}} : {CH{8'd6}};
      step();
      want_v = (k == ROUND) || (k == 2 * ROUND);
      nvec++;
      if (data_out_valid !== want_v) begin
        nerr++;
        $display("FAIL b2b valid edge %0d: got %b want %b", k, data_out_valid, want_v);
      end
      if (want_v) begin
        want_d = (k == ROUND) ? {CH{4'd9}} : {CH{4'd13}};
        nvec++;
        if (data_out !== want_d) begin
          nerr++;
          $display("FAIL b2b data edge %0d: got %h want %h", k, data_out, want_d);
        end
      end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    data_in = {CH{8'd10}};
    for (int b = 0; b < 5; b++) begin
      data_in_valid = 1'b1;
      step();
    end
    data_in_valid = 1'b0;
    rstn          = 1'b0;
    step();
    rstn = 1'b1;
    nvec++;
    if (data_out_valid !== 1'b0 || data_out !== '0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: valid %b busy %b data %h want all 0", data_out_valid, busy, data_out);
    end
    bias_in = '0;
    fill_const(8'd2);
    run_pixel("post_reset", 0);
    nvec++;
    if (data_out !== {CH{4'd4}}) begin
      nerr++;
      $display("FAIL post_reset const: got %h want all 4", data_out);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < CH; c++) begin
        bias_in[c] = 8'($urandom);
        for (int b = 0; b < ROUND; b++) beats[b][c] = 8'($urandom);
      end
      run_pixel("random", 2);
    end
  endtask

  initial begin
    nvec          = 0;
    nerr          = 0;
    rstn          = 1'b0;
    clear         = 1'b0;
    data_in_valid = 1'b0;
    data_in       = '0;
    bias_in       = '0;
    test_reset();
    test_basic();
    test_saturate_relu();
    test_idle();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
